// File: rtl/pdl_pkg.sv
// Shared constants and the controller state type for the PDL pointer/strobe block.
package pdl_pkg;

  localparam int PDL_AW = 10;

  typedef enum logic {
    S_RUN = 1'b0,
    S_WB  = 1'b1
  } state_t;

  localparam logic SEL_PTR = 1'b0;
  localparam logic SEL_IDX = 1'b1;

endpackage

// File: rtl/pdl_ptr_reg.sv
// AW-bit stack pointer register: load, increment or decrement on enable,
// with single-cycle pulses when an increment or decrement wraps around.
module pdl_ptr_reg #(
  parameter int              AW        = 10,
  parameter logic [AW-1:0]   RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          ld,
  input  logic          inc,
  input  logic          dec,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] q,
  output logic [AW-1:0] adj,
  output logic          wrap_up,
  output logic          wrap_dn
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic step_up;
  logic step_dn;

  // inc and dec together cancel; adj ignores ld so the write address stays pre-load
  assign step_up = inc & ~dec;
  assign step_dn = dec & ~inc;
  assign adj     = step_up ? (q + ONE) : (step_dn ? (q - ONE) : q);

  assign wrap_up = en & ~ld & step_up & (q == {AW{1'b1}});
  assign wrap_dn = en & ~ld & step_dn & (q == {AW{1'b0}});

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= ld ? d : adj;
    end
  end

endmodule

// File: rtl/pdl_ptr_ctl.sv
// PDL pointer/index registers plus address and strobe generation for the 1Kx32
// PDL buffer; writes are deferred to a one-cycle write-back slot.
import pdl_pkg::*;

module pdl_ptr_ctl #(
  parameter int            AW        = PDL_AW,
  parameter logic [AW-1:0] PTR_RESET = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic          rd_en,
  input  logic          rd_sel,
  input  logic          pop,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic          push,
  input  logic          ld_ptr,
  input  logic          ld_idx,
  input  logic [AW-1:0] ob,
  output logic [AW-1:0] pdla,
  output logic          prp,
  output logic          pwp,
  output logic          bypass,
  output logic [AW-1:0] pdlptr,
  output logic [AW-1:0] pdlidx,
  output logic          ovf,
  output logic          unf,
  output logic          fsm_state
);

  // Handshake: an op is taken on any clk edge where op_valid & op_ready; op_ready
  // drops for the write-back cycle, and the op fields must be held until taken.

  state_t        state;
  logic          accept;
  logic          prev_wb;
  logic          wrap_up;
  logic          wrap_dn;
  logic [AW-1:0] ptr_adj;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] wr_addr_q;

  pdl_ptr_reg #(
    .AW        (AW),
    .RESET_VAL (PTR_RESET)
  ) u_ptr (
    .clk     (clk),
    .reset   (reset),
    .en      (accept),
    .ld      (ld_ptr),
    .inc     (push),
    .dec     (pop),
    .d       (ob),
    .q       (pdlptr),
    .adj     (ptr_adj),
    .wrap_up (wrap_up),
    .wrap_dn (wrap_dn)
  );

  assign op_ready  = reset & (state == S_RUN);
  assign accept    = op_valid & op_ready;
  assign prp       = accept & rd_en;
  assign pwp       = reset & (state == S_WB);
  assign fsm_state = state;

  assign rd_addr = (rd_sel == SEL_PTR) ? pdlptr : pdlidx;
  assign wr_addr = (wr_sel == SEL_IDX) ? pdlidx : ptr_adj;

  always_comb begin
    pdla = '0;
    if (reset) begin
      if (state == S_WB) begin
        pdla = wr_addr_q;
      end else if (prp) begin
        pdla = rd_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_RUN;
      pdlidx    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      bypass    <= 1'b0;
      prev_wb   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      prev_wb <= (state == S_WB);
      // wr_addr_q still holds the address just written when a read follows S_WB
      bypass  <= prp & prev_wb & (rd_addr == wr_addr_q);
      case (state)
        S_RUN: begin
          if (accept && wr_en) begin
            wr_addr_q <= wr_addr;
            state     <= S_WB;
          end
        end
        default: state <= S_RUN;
      endcase
      if (accept && ld_idx) begin
        pdlidx <= ob;
      end
      if (accept && ld_ptr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        if (wrap_up) ovf <= 1'b1;
        if (wrap_dn) unf <= 1'b1;
      end
    end
  end

endmodule
